line_buffer_scheduler: RTL and testbench
========================================

Name: line_buffer_scheduler

Overview:
Write-side controller for the shared line-buffer RAM that the video output stage reads.
- Sequences incoming captured pixels into RAM line slots (address generation, write enable, wrap).
- Tracks buffered lines per frame and issues the start trigger to the output stage once enough lines are resident.
- Sits between the capture front end and the RAM write port; its starttrigger feeds the output generator.

Parameters:
ADDR_BITS, 15, RAM address width (matches RAM_ADDRESS_BITS)
LINE_LENGTH, 640, pixels stored per line slot
NUM_LINES, 48, line slots in RAM; NUM_LINES*LINE_LENGTH <= 2**ADDR_BITS
START_LINES, 2, completed lines of a frame required before starttrigger
VISIBLE_LINES, 480, maximum lines counted per frame

Ports:
clock  in  1  pixel-domain clock, single clock for block
reset  in  1  synchronous, active-high reset
in_pixel_valid  in  1  one captured pixel this cycle
in_pixel_data  in  24  RGB888 pixel
in_line_start  in  1  pulse, start of new input line
in_frame_start  in  1  pulse, start of new input frame (implies line 0)
mode_change  in  1  pulse, output mode changed (line doubler / add line); forces resync
wraddr  out  ADDR_BITS  RAM write address
wrdata  out  24  RAM write data
wren  out  1  RAM write enable
starttrigger  out  1  one-cycle pulse per frame when START_LINES lines are buffered
lines_written  out  10  completed lines in current frame, saturating at VISIBLE_LINES
overflow_err  out  1  sticky: pixel beyond LINE_LENGTH dropped

Behaviour:
- Reset values: wraddr=0, wrdata=0, wren=0, starttrigger=0, lines_written=0, overflow_err=0, state=SYNC, x=0, line_base=0.
- FSM states:
  - SYNC: ignore pixels; wren=0. On in_frame_start, go to FILL.
  - FILL: capture pixels. When lines_written reaches START_LINES, go to RUN and pulse starttrigger for one cycle.
  - RUN: capture pixels. On in_frame_start, go to FILL; the next frame re-pulses starttrigger.
- mode_change (any state): go to SYNC next cycle; clear x, line_base, lines_written; starttrigger=0. overflow_err is retained.
- reset mid-operation: identical to the reset values above; overflow_err is also cleared.
- Write path, latency 1: the pixel accepted in cycle N gives wren=1, wraddr=line_base+x and wrdata in cycle N+1. Then x<=x+1.
- x == LINE_LENGTH: pixel is dropped, wren=0, overflow_err<=1.
- in_line_start:
  - x>0: line completes. lines_written+1 (saturating). line_base+=LINE_LENGTH, wrapping to 0 when line_base == (NUM_LINES-1)*LINE_LENGTH. x<=0.
  - x==0: no-op; empty lines are not counted.
- in_frame_start: line_base<=0, x<=0, lines_written<=0. Takes priority over a simultaneous in_line_start.
- Pixel in the same cycle as line/frame start: the start is applied first, and the pixel is written at new line_base + 0.
- mode_change in the same cycle as in_frame_start: mode_change wins (state=SYNC).
- Address arithmetic is unsigned ADDR_BITS wide; line_base is always a multiple of LINE_LENGTH, with no partial wrap.

Optional Feature:
LINE_BUFFER_TESTPATTERN_EN
- Defined: wrdata is replaced by 8 vertical colour bars selected by x*8/LINE_LENGTH (white, yellow, cyan, green, magenta, red, blue, black, each 8'hFF/8'h00 per component). Timing, wren and addressing are still paced by in_pixel_valid; in_pixel_data is ignored.
- Undefined: wrdata = registered in_pixel_data.

Decomposition:
- Shared include (config.inc): LINE_LENGTH, NUM_LINES, RAM_ADDRESS_BITS, VISIBLE_LINES, FSM state encodings (SYNC=0, FILL=1, RUN=2) and colour-bar constants.
- One natural sub-module: line_buffer_addr_gen, which holds x/line_base counters, wrap and overflow detection; the FSM stays in the top.

Test Plan:
- Reset, then in_frame_start, then 640 valid pixels, then in_line_start -> wraddr 0..639 with wren each cycle, one cycle after the pixel; lines_written=1; no starttrigger.
- Second line of 640 pixels plus in_line_start -> lines_written=2; starttrigger high exactly 1 cycle; state RUN; next pixel at wraddr 1280.
- 48 full lines -> line 48 written at wraddr 0 (wrap); lines_written=48.
- 645 pixels in one line -> wraddr stops at 639; 5 dropped with wren=0; overflow_err=1 and stays 1 after in_frame_start.
- mode_change mid-line 3 -> wren=0 and pixels ignored until in_frame_start; then first pixel at wraddr 0, starttrigger again after 2 lines.
- in_frame_start, in_line_start and in_pixel_valid in the same cycle (data 24'h123456) -> wraddr=0, wrdata=24'h123456, lines_written=0.

Source files
------------

// File: rtl/line_buffer_scheduler_pkg.sv
// Shared constants, FSM encoding and colour-bar table for the line-buffer write side.
// Optional build macro used by this block: LINE_BUFFER_TESTPATTERN_EN.
package line_buffer_scheduler_pkg;

    localparam int unsigned RAM_ADDRESS_BITS  = 15;
    localparam int unsigned DEF_LINE_LENGTH   = 640;
    localparam int unsigned DEF_NUM_LINES     = 48;
    localparam int unsigned DEF_START_LINES   = 2;
    localparam int unsigned DEF_VISIBLE_LINES = 480;
    localparam int unsigned PIXEL_BITS        = 24;
    localparam int unsigned LINE_COUNT_BITS   = 10;

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    localparam logic [PIXEL_BITS-1:0] BAR_WHITE   = 24'hFFFFFF;
    localparam logic [PIXEL_BITS-1:0] BAR_YELLOW  = 24'hFFFF00;
    localparam logic [PIXEL_BITS-1:0] BAR_CYAN    = 24'h00FFFF;
    localparam logic [PIXEL_BITS-1:0] BAR_GREEN   = 24'h00FF00;
    localparam logic [PIXEL_BITS-1:0] BAR_MAGENTA = 24'hFF00FF;
    localparam logic [PIXEL_BITS-1:0] BAR_RED     = 24'hFF0000;
    localparam logic [PIXEL_BITS-1:0] BAR_BLUE    = 24'h0000FF;
    localparam logic [PIXEL_BITS-1:0] BAR_BLACK   = 24'h000000;

    // Colour of vertical bar idx, left (white) to right (black).
    function automatic logic [PIXEL_BITS-1:0] bar_colour(input logic [2:0] idx);
        logic [PIXEL_BITS-1:0] c;
        case (idx)
            3'd0:    c = BAR_WHITE;
            3'd1:    c = BAR_YELLOW;
            3'd2:    c = BAR_CYAN;
            3'd3:    c = BAR_GREEN;
            3'd4:    c = BAR_MAGENTA;
            3'd5:    c = BAR_RED;
            3'd6:    c = BAR_BLUE;
            default: c = BAR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/line_buffer_addr_gen.sv
// Column / line-slot counters for the line-buffer RAM write port.
// Ports:
//   clock, reset       : clock and synchronous active-high reset
//   clear              : resync request, zeroes both counters (highest priority)
//   frame_start        : restart at slot 0, column 0
//   line_start         : close the current line if it holds any pixels
//   pixel_valid        : pixel accepted this cycle (already gated by the FSM)
//   addr_c             : address for the accepted pixel (new line applied first)
//   write_c / drop_c   : pixel stored / pixel dropped because the line is full
//   line_done_c        : a non-empty line was closed this cycle
//   bar_idx_c          : colour bar of the current column (LINE_BUFFER_TESTPATTERN_EN only)
module line_buffer_addr_gen #(
    parameter int unsigned ADDR_BITS   = 15,
    parameter int unsigned LINE_LENGTH = 640,
    parameter int unsigned NUM_LINES   = 48
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 frame_start,
    input  logic                 line_start,
    input  logic                 pixel_valid,
    output logic [ADDR_BITS-1:0] addr_c,
    output logic                 write_c,
    output logic                 drop_c,
    output logic                 line_done_c
`ifdef LINE_BUFFER_TESTPATTERN_EN
    ,
    output logic [2:0]           bar_idx_c
`endif
);

    localparam int unsigned          X_BITS    = $clog2(LINE_LENGTH + 1);
    localparam logic [X_BITS-1:0]    X_FULL    = X_BITS'(LINE_LENGTH);
    localparam logic [ADDR_BITS-1:0] BASE_STEP = ADDR_BITS'(LINE_LENGTH);
    localparam logic [ADDR_BITS-1:0] BASE_LAST = ADDR_BITS'((NUM_LINES - 1) * LINE_LENGTH);

    logic [X_BITS-1:0]    x;
    logic [X_BITS-1:0]    x_eff;
    logic [X_BITS-1:0]    x_next;
    logic [ADDR_BITS-1:0] line_base;
    logic [ADDR_BITS-1:0] base_eff;
    logic [ADDR_BITS-1:0] base_next;

    // Position after this cycle's frame/line start, before the pixel lands.
    always_comb begin
        x_eff       = x;
        base_eff    = line_base;
        line_done_c = 1'b0;
        if (clear) begin
            x_eff    = '0;
            base_eff = '0;
        end else if (frame_start) begin
            x_eff    = '0;
            base_eff = '0;
        end else if (line_start && (x != '0)) begin
            line_done_c = 1'b1;
            x_eff       = '0;
            base_eff    = (line_base == BASE_LAST) ? '0 : line_base + BASE_STEP;
        end
    end

    // Pixel placement and overflow detection.
    always_comb begin
        write_c   = 1'b0;
        drop_c    = 1'b0;
        x_next    = x_eff;
        base_next = base_eff;
        addr_c    = base_eff + ADDR_BITS'(x_eff);
        if (!clear && pixel_valid) begin
            if (x_eff == X_FULL) begin
                drop_c = 1'b1;
            end else begin
                write_c = 1'b1;
                x_next  = x_eff + 1'b1;
            end
        end
    end

`ifdef LINE_BUFFER_TESTPATTERN_EN
    // Eight equal-width bars across the line.
    assign bar_idx_c = 3'((32'(x_eff) * 32'd8) / 32'(LINE_LENGTH));
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            x         <= '0;
            line_base <= '0;
        end else begin
            x         <= x_next;
            line_base <= base_next;
        end
    end

endmodule

// File: rtl/line_buffer_scheduler.sv
// Write-side controller of the shared line-buffer RAM: places captured pixels
// into line slots, counts completed lines per frame and fires starttrigger
// once START_LINES lines are resident.
// Optional build macro: LINE_BUFFER_TESTPATTERN_EN replaces pixel data by colour bars.
// Ports:
//   clock, reset          : pixel clock, synchronous active-high reset
//   in_pixel_valid/data   : captured RGB888 pixel
//   in_line_start         : start of input line
//   in_frame_start        : start of input frame
//   mode_change           : output mode changed, forces resync
//   wraddr/wrdata/wren    : RAM write port (one cycle after the pixel)
//   starttrigger          : one-cycle pulse per frame to the output generator
//   lines_written         : completed lines this frame, saturating
//   overflow_err          : sticky, a pixel beyond the line length was dropped
module line_buffer_scheduler
    import line_buffer_scheduler_pkg::*;
#(
    parameter int unsigned ADDR_BITS     = RAM_ADDRESS_BITS,
    parameter int unsigned LINE_LENGTH   = DEF_LINE_LENGTH,
    parameter int unsigned NUM_LINES     = DEF_NUM_LINES,
    parameter int unsigned START_LINES   = DEF_START_LINES,
    parameter int unsigned VISIBLE_LINES = DEF_VISIBLE_LINES
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_pixel_valid,
    input  logic [PIXEL_BITS-1:0]      in_pixel_data,
    input  logic                       in_line_start,
    input  logic                       in_frame_start,
    input  logic                       mode_change,
    output logic [ADDR_BITS-1:0]       wraddr,
    output logic [PIXEL_BITS-1:0]      wrdata,
    output logic                       wren,
    output logic                       starttrigger,
    output logic [LINE_COUNT_BITS-1:0] lines_written,
    output logic                       overflow_err
);

    localparam logic [LINE_COUNT_BITS-1:0] LINES_MAX   = LINE_COUNT_BITS'(VISIBLE_LINES);
    localparam logic [LINE_COUNT_BITS-1:0] LINES_START = LINE_COUNT_BITS'(START_LINES);

    state_e                       state;
    state_e                       state_next;
    logic                         trig_next;
    logic [LINE_COUNT_BITS-1:0]   lines_next;
    logic                         pixel_accept_c;
    logic [ADDR_BITS-1:0]         addr_c;
    logic                         write_c;
    logic                         drop_c;
    logic                         line_done_c;
    logic [PIXEL_BITS-1:0]        pixel_c;

    // A frame start received while in SYNC already captures its own pixel.
    assign pixel_accept_c = in_pixel_valid && ((state != ST_SYNC) || in_frame_start);

    line_buffer_addr_gen #(
        .ADDR_BITS   (ADDR_BITS),
        .LINE_LENGTH (LINE_LENGTH),
        .NUM_LINES   (NUM_LINES)
    ) u_addr_gen (
        .clock       (clock),
        .reset       (reset),
        .clear       (mode_change),
        .frame_start (in_frame_start),
        .line_start  (in_line_start),
        .pixel_valid (pixel_accept_c),
        .addr_c      (addr_c),
        .write_c     (write_c),
        .drop_c      (drop_c),
        .line_done_c (line_done_c)
`ifdef LINE_BUFFER_TESTPATTERN_EN
        ,
        .bar_idx_c   (bar_idx_c)
`endif
    );

`ifdef LINE_BUFFER_TESTPATTERN_EN
    logic [2:0] bar_idx_c;
    assign pixel_c = bar_colour(bar_idx_c);
`else
    assign pixel_c = in_pixel_data;
`endif

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_SYNC;
        end else begin
            state <= state_next;
        end
    end

    // Next state, line count and trigger.
    always_comb begin
        state_next = state;
        trig_next  = 1'b0;
        lines_next = lines_written;
        if (mode_change) begin
            state_next = ST_SYNC;
            lines_next = '0;
        end else if (in_frame_start) begin
            state_next = ST_FILL;
            lines_next = '0;
        end else begin
            if (line_done_c && (lines_written < LINES_MAX)) begin
                lines_next = lines_written + 1'b1;
            end
            case (state)
                ST_SYNC: state_next = ST_SYNC;
                ST_FILL: begin
                    if (lines_next == LINES_START) begin
                        state_next = ST_RUN;
                        trig_next  = 1'b1;
                    end
                end
                ST_RUN:  state_next = ST_RUN;
                default: state_next = ST_SYNC;
            endcase
        end
    end

    // Registered write port and status outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            wraddr        <= '0;
            wrdata        <= '0;
            wren          <= 1'b0;
            starttrigger  <= 1'b0;
            lines_written <= '0;
            overflow_err  <= 1'b0;
        end else begin
            wren          <= write_c;
            starttrigger  <= trig_next;
            lines_written <= lines_next;
            if (write_c) begin
                wraddr <= addr_c;
                wrdata <= pixel_c;
            end
            if (drop_c) begin
                overflow_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_line_buffer_scheduler.sv
module tb_line_buffer_scheduler;

    localparam int unsigned AW = 15;
    localparam int unsigned LL = 640;
    localparam int unsigned NL = 48;
    localparam int unsigned SL = 2;
    localparam int unsigned VL = 480;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          in_pixel_valid = 1'b0;
    logic [23:0]   in_pixel_data = '0;
    logic          in_line_start = 1'b0;
    logic          in_frame_start = 1'b0;
    logic          mode_change = 1'b0;
    logic [AW-1:0] wraddr;
    logic [23:0]   wrdata;
    logic          wren;
    logic          starttrigger;
    logic [9:0]    lines_written;
    logic          overflow_err;

    always #5 clock = ~clock;

    line_buffer_scheduler #(
        .ADDR_BITS     (AW),
        .LINE_LENGTH   (LL),
        .NUM_LINES     (NL),
        .START_LINES   (SL),
        .VISIBLE_LINES (VL)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .in_pixel_valid (in_pixel_valid),
        .in_pixel_data  (in_pixel_data),
        .in_line_start  (in_line_start),
        .in_frame_start (in_frame_start),
        .mode_change    (mode_change),
        .wraddr         (wraddr),
        .wrdata         (wrdata),
        .wren           (wren),
        .starttrigger   (starttrigger),
        .lines_written  (lines_written),
        .overflow_err   (overflow_err)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: slot index and column as plain integers.
    bit          m_sync;
    bit          m_armed;
    bit          m_ovf;
    int          m_x;
    int          m_slot;
    int          m_lines;
    bit          e_wren;
    bit          e_trig;
    int          e_addr;
    logic [23:0] e_data;

    function automatic logic [23:0] bar_ref(input int idx);
        logic [23:0] t [8];
        t = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        return t[idx];
    endfunction

    task automatic model_reset();
        m_sync = 0; m_armed = 0; m_ovf = 0;
        m_x = 0; m_slot = 0; m_lines = 0;
        e_wren = 0; e_trig = 0;
    endtask

    task automatic model_step(input bit pv, input logic [23:0] d, input bit ls, input bit fs, input bit mc);
        e_wren = 0;
        e_trig = 0;
        if (mc) begin
            m_sync = 0; m_x = 0; m_slot = 0; m_lines = 0;
        end else begin
            if (fs) begin
                m_sync = 1; m_armed = 1; m_x = 0; m_slot = 0; m_lines = 0;
            end else if (ls && m_x > 0) begin
                m_slot = (m_slot + 1) % NL;
                m_x = 0;
                if (m_lines < VL) m_lines++;
                if (m_sync && m_armed && m_lines == SL) begin
                    e_trig = 1;
                    m_armed = 0;
                end
            end
            if (pv && m_sync) begin
                if (m_x == LL) begin
                    m_ovf = 1;
                end else begin
                    e_wren = 1;
                    e_addr = m_slot * LL + m_x;
`ifdef LINE_BUFFER_TESTPATTERN_EN
                    e_data = bar_ref((m_x * 8) / LL);
`else
                    e_data = d;
`endif
                    m_x++;
                end
            end
        end
    endtask

    task automatic cycle(input bit pv, input logic [23:0] d, input bit ls, input bit fs, input bit mc);
        in_pixel_valid = pv;
        in_pixel_data  = d;
        in_line_start  = ls;
        in_frame_start = fs;
        mode_change    = mc;
        model_step(pv, d, ls, fs, mc);
        @(posedge clock);
        #1;
        check("wren", 32'(wren), 32'(e_wren));
        if (e_wren) begin
            check("wraddr", 32'(wraddr), 32'(e_addr));
            check("wrdata", 32'(wrdata), 32'(e_data));
        end
        check("starttrigger", 32'(starttrigger), 32'(e_trig));
        check("lines_written", 32'(lines_written), 32'(m_lines));
        check("overflow_err", 32'(overflow_err), 32'(m_ovf));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_pixel_valid = 0; in_line_start = 0; in_frame_start = 0; mode_change = 0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
        check("rst_wren", 32'(wren), 32'd0);
        check("rst_wraddr", 32'(wraddr), 32'd0);
        check("rst_wrdata", 32'(wrdata), 32'd0);
        check("rst_trig", 32'(starttrigger), 32'd0);
        check("rst_lines", 32'(lines_written), 32'd0);
        check("rst_ovf", 32'(overflow_err), 32'd0);
    endtask

    // n pixels of random data, then a line start with no pixel.
    task automatic send_line(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 24'($urandom), 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 24'h0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        do_reset();

        // First two lines of a frame, trigger, then wrap through all slots.
        cycle(0, 24'h0, 0, 1, 0);
        send_line(LL);
        send_line(LL);
        cycle(1, 24'hABCDEF, 0, 0, 0);
        cycle(0, 24'h0, 1, 0, 0);
        for (int l = 0; l < NL - 3; l++) send_line(LL);
        cycle(1, 24'h00C0DE, 0, 0, 0);
        cycle(0, 24'h0, 1, 0, 0);

        // Overlong line, overflow must survive a new frame.
        cycle(0, 24'h0, 0, 1, 0);
        send_line(LL + 5);
        cycle(0, 24'h0, 0, 1, 0);
        send_line(10);

        // Resync in the middle of the third line.
        cycle(0, 24'h0, 0, 1, 0);
        send_line(LL);
        send_line(LL);
        for (int i = 0; i < 100; i++) cycle(1, 24'($urandom), 0, 0, 0);
        cycle(1, 24'h111111, 0, 0, 1);
        for (int i = 0; i < 20; i++) cycle(1, 24'($urandom), 0, 0, 0);
        cycle(0, 24'h0, 1, 0, 0);
        cycle(1, 24'h222222, 0, 1, 0);
        send_line(LL - 1);
        send_line(LL);
        send_line(5);

        // Frame start, line start and pixel together.
        cycle(1, 24'h123456, 1, 1, 0);
        cycle(1, 24'h654321, 0, 0, 0);

        // Mode change colliding with a frame start.
        cycle(1, 24'h777777, 0, 1, 1);
        cycle(1, 24'h888888, 0, 0, 0);

        // Randomised traffic with occasional mid-operation reset.
        cycle(0, 24'h0, 0, 1, 0);
        for (int i = 0; i < 30000; i++) begin
            if ($urandom_range(0, 9999) == 0) begin
                do_reset();
            end else begin
                cycle(1'($urandom_range(0, 9) < 7), 24'($urandom),
                      1'($urandom_range(0, 999) == 0),
                      1'($urandom_range(0, 2999) == 0),
                      1'($urandom_range(0, 4999) == 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
